dac_input_sequencer: RTL and testbench
======================================

# dac_input_sequencer

Upstream feeder for the 10-bit wordline DAC. It buffers an incoming stream of activation values in a small FIFO and expands each one to a DAC code. It issues exactly one code per DAC conversion, holding off until the DAC reports completion, and tracks the wordline row index and end-of-vector.

## Interface
Parameters:
- DAC_BITS, 10, DAC code width; must satisfy IN_BITS <= DAC_BITS <= 2*IN_BITS
- IN_BITS, 8, activation width
- DEPTH, 4, FIFO entries (power of two, >= 2)
- ROW_BITS, 7, row index width
- TIMEOUT_CYC, 16, max cycles to wait for dac_done after an issue

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  IN_BITS  activation value
- in_last  in  1  marks final element of a vector
- in_valid  in  1  upstream data valid
- in_ready  out  1  FIFO can accept; = (count < DEPTH)
- dac_code  out  DAC_BITS  code to DAC digital input
- dac_valid  out  1  one-cycle issue pulse to DAC valid input
- dac_done  in  1  DAC conversion-complete pulse
- row_idx  out  ROW_BITS  row of the element currently issued
- vec_done  out  1  one-cycle pulse on dac_done of a last element
- err_clr  in  1  clears err_timeout
- err_timeout  out  1  sticky timeout flag
- busy  out  1  state != IDLE or count != 0

## Operation
- Reset values: in_ready 1, dac_code 0, dac_valid 0, row_idx 0, vec_done 0, err_timeout 0, busy 0. FIFO is emptied (count 0). State is IDLE and the timeout counter is 0.
- FIFO:
  - Entry = {in_last, in_data}.
  - Push on in_valid && in_ready. Pop is internal.
  - Push and pop in the same cycle leave count unchanged. A push when full cannot occur because in_ready is 0.
  - Pointers wrap modulo DEPTH.
- Code expansion: dac_code = (in_data << S) | (in_data >> (IN_BITS - S)), with S = DAC_BITS - IN_BITS.
  - Worked values for 8->10: 0->0, 255->1023, 128->514, 1->4.
- States:
  - IDLE: if count != 0, pop, register dac_code and the last bit, pulse dac_valid, go to WAIT. Otherwise stay.
  - WAIT: the timeout counter increments every cycle.
    - On dac_done: if the held entry was last, pulse vec_done and set row_idx to 0; otherwise row_idx += 1.
    - Then, if count != 0, pop and issue immediately (pulse dac_valid, stay in WAIT, counter to 0). Otherwise go to IDLE.
    - If the counter reaches TIMEOUT_CYC without dac_done: set err_timeout, drop the element, advance row_idx by the same rule as dac_done (no vec_done), go to IDLE.
- dac_done is ignored in IDLE.
- row_idx wraps modulo 2^ROW_BITS.
- err_clr clears err_timeout. If a timeout and err_clr occur in the same cycle, set wins.
- dac_code holds its value between issues.
- rst mid-operation: everything returns to reset values on the next edge. Buffered data is lost. A dac_done arriving after reset is ignored.

## Timing
- Element accepted in cycle c0 with the sequencer IDLE and the FIFO empty: pop at end of c1, dac_valid high in c2.
- With the 4-state DAC (captures in IDLE, valid_out 4 cycles later):
  - dac_done arrives in c6.
  - The next dac_valid is in c7.
  - Steady-state throughput is 1 element per 5 cycles.
- dac_valid is never high on consecutive cycles. It is never asserted while waiting for an outstanding dac_done.
- vec_done and the row_idx update take effect the cycle after dac_done.
- in_ready depends only on registered count. There is no combinational path from in_valid.

## Test plan
- Reset then push one element 255 with last=1: dac_valid high exactly 2 cycles after accept with dac_code 1023. Respond with dac_done 4 cycles later: vec_done pulses once, row_idx = 0, busy drops.
- Push vector 0,1,128,200 (last on 200) back-to-back: in_ready drops after 4 entries. Codes issued are 0, 4, 514, 803 at 5-cycle spacing. row_idx is 0..3 at each issue, then returns to 0 with one vec_done.
- Push and pop in the same cycle while FIFO holds 2: count stays 2 and entry order is preserved.
- Withhold dac_done after an issue: err_timeout sets at TIMEOUT_CYC (16) cycles, the element is dropped, and row_idx advances. Assert err_clr: flag clears. The next queued element issues normally.
- Spurious dac_done while IDLE: no state, row_idx or vec_done change.
- Assert rst while in WAIT with 3 entries buffered: all outputs return to reset values the next cycle. A late dac_done produces no response.

Source files
------------

// File: rtl/dac_input_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dac_input_sequencer
// Purpose  : Buffers activation values and issues one expanded code per DAC
//            conversion, tracking the wordline row index and end-of-vector.
// Revision : 1.0 - initial release
// ============================================================================
module dac_input_sequencer #(
    parameter int DAC_BITS    = 10,
    parameter int IN_BITS     = 8,
    parameter int DEPTH       = 4,
    parameter int ROW_BITS    = 7,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_BITS-1:0]  in_data,
    input  logic                in_last,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DAC_BITS-1:0] dac_code,
    output logic                dac_valid,
    input  logic                dac_done,
    output logic [ROW_BITS-1:0] row_idx,
    output logic                vec_done,
    input  logic                err_clr,
    output logic                err_timeout,
    output logic                busy
);

    localparam int c_S     = DAC_BITS - IN_BITS;
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_TMO_W = $clog2(TIMEOUT_CYC) + 1;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_WAIT = 1'b1;

    logic [IN_BITS:0]      r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [c_TMO_W-1:0]    r_tmo_cnt;
    logic                  r_held_last;
    logic [DAC_BITS-1:0]   r_dac_code;
    logic                  r_dac_valid;
    logic [ROW_BITS-1:0]   r_row_idx;
    logic                  r_vec_done;
    logic                  r_err_timeout;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_done_ok;
    logic                  w_timeout;
    logic [IN_BITS:0]      w_head;
    logic [DAC_BITS-1:0]   w_head_wide;
    logic [DAC_BITS-1:0]   w_code;

    assign in_ready    = (r_count < c_CNT_W'(DEPTH));
    assign w_push      = in_valid && in_ready;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_wide = DAC_BITS'(w_head[IN_BITS-1:0]);
    // Replicating the top bits into the low end maps full scale to full scale.
    assign w_code      = (w_head_wide << c_S) | (w_head_wide >> (IN_BITS - c_S));

    assign dac_code    = r_dac_code;
    assign dac_valid   = r_dac_valid;
    assign row_idx     = r_row_idx;
    assign vec_done    = r_vec_done;
    assign err_timeout = r_err_timeout;
    assign busy        = (r_state != c_ST_IDLE) || (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_done_ok   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (dac_done) begin
                    w_done_ok = 1'b1;
                    if (r_count != '0) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end else if (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYC - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Storage carries no reset; occupancy is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_last, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dac_code    <= '0;
            r_dac_valid   <= 1'b0;
            r_held_last   <= 1'b0;
            r_row_idx     <= '0;
            r_vec_done    <= 1'b0;
            r_tmo_cnt     <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_dac_valid <= w_pop;
            r_vec_done  <= w_done_ok && r_held_last;
            if (w_pop) begin
                r_dac_code  <= w_code;
                r_held_last <= w_head[IN_BITS];
            end
            // A timed-out element still consumes its row slot.
            if (w_done_ok || w_timeout) begin
                r_row_idx <= r_held_last ? '0 : r_row_idx + ROW_BITS'(1);
            end
            if (w_pop) begin
                r_tmo_cnt <= '0;
            end else if (r_state == c_ST_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end else if (err_clr) begin
                r_err_timeout <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dac_input_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_input_sequencer
// Purpose  : Directed + randomized bench with a transaction-level model of
//            the sequencer and a 4-cycle DAC responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_input_sequencer;

    localparam int DAC_BITS    = 10;
    localparam int IN_BITS     = 8;
    localparam int DEPTH       = 4;
    localparam int ROW_BITS    = 7;
    localparam int TIMEOUT_CYC = 16;
    localparam int S           = DAC_BITS - IN_BITS;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [IN_BITS-1:0]  in_data = '0;
    logic                in_last = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [DAC_BITS-1:0] dac_code;
    logic                dac_valid;
    logic                dac_done;
    logic [ROW_BITS-1:0] row_idx;
    logic                vec_done;
    logic                err_clr = 1'b0;
    logic                err_timeout;
    logic                busy;
    logic                resp_done = 1'b0;
    logic                spur_done = 1'b0;

    assign dac_done = resp_done | spur_done;

    always #5 clk = ~clk;

    dac_input_sequencer #(
        .DAC_BITS(DAC_BITS), .IN_BITS(IN_BITS), .DEPTH(DEPTH),
        .ROW_BITS(ROW_BITS), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready), .dac_code(dac_code),
        .dac_valid(dac_valid), .dac_done(dac_done), .row_idx(row_idx),
        .vec_done(vec_done), .err_clr(err_clr), .err_timeout(err_timeout),
        .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: elements accepted but not yet issued, and the one in flight.
    int mq_data[$];
    bit mq_last[$];
    int out_data;
    bit out_last;
    bit outstanding = 0;
    bit out_resp = 0;
    int issue_t = 0;
    int model_row = 0;
    int n_push = 0;
    int n_issue = 0;
    int issue_cyc[$];
    bit saw_full = 0;
    bit prev_valid = 0;
    bit resp_en = 1;
    int resp_lat = 4;
    int dly = -1;
    bit pend = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int expand(input int x);
        return x * (1 << S) + x / (1 << (IN_BITS - S));
    endfunction

    function automatic int next_row(input bit last, input int row);
        return last ? 0 : (row + 1) % (1 << ROW_BITS);
    endfunction

    task automatic nclk(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int d, input bit l);
        for (int g = 0; g < 200; g++) begin
            chk("in_ready_vs_occupancy", in_ready, (n_push - n_issue) < DEPTH);
            if (in_ready) break;
            saw_full = 1;
            nclk();
        end
        chk("push_accept_window", in_ready, 1);
        in_data  = IN_BITS'(d);
        in_last  = l;
        in_valid = 1'b1;
        mq_data.push_back(d);
        mq_last.push_back(l);
        nclk();
        n_push++;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int g = 0; g < 400 && (busy || outstanding); g++) nclk();
        chk("drain_busy", busy, 0);
        chk("drain_outstanding", outstanding, 0);
    endtask

    task automatic check_reset_outputs(input string where);
        chk({where, "_in_ready"}, in_ready, 1);
        chk({where, "_dac_code"}, dac_code, 0);
        chk({where, "_dac_valid"}, dac_valid, 0);
        chk({where, "_row_idx"}, row_idx, 0);
        chk({where, "_vec_done"}, vec_done, 0);
        chk({where, "_err_timeout"}, err_timeout, 0);
        chk({where, "_busy"}, busy, 0);
    endtask

    // Monitor, scoreboard and DAC responder, acting just after each edge.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        resp_done = 1'b0;
        if (rst) begin
            mq_data.delete();
            mq_last.delete();
            dly = -1;
            pend = 0;
            outstanding = 0;
            out_resp = 0;
            model_row = 0;
            prev_valid = 0;
        end else begin
            if (pend) begin
                pend = 0;
                outstanding = 0;
                model_row = next_row(out_last, model_row);
                chk("vec_done_on_done", vec_done, out_last);
                chk("row_after_done", row_idx, model_row);
            end else if (outstanding && !out_resp && cyc == issue_t + TIMEOUT_CYC) begin
                outstanding = 0;
                model_row = next_row(out_last, model_row);
                chk("err_timeout_set", err_timeout, 1);
                chk("vec_done_on_timeout", vec_done, 0);
                chk("row_after_timeout", row_idx, model_row);
            end else begin
                chk("vec_done_quiet", vec_done, 0);
                if (outstanding && !out_resp && cyc == issue_t + TIMEOUT_CYC - 1)
                    chk("err_timeout_early", err_timeout, 0);
            end
            if (dly == 0) begin
                resp_done = 1'b1;
                dly = -1;
                pend = 1;
            end else if (dly > 0) begin
                dly--;
            end
            if (dac_valid) begin
                chk("valid_not_back_to_back", prev_valid, 0);
                chk("no_issue_while_outstanding", outstanding, 0);
                chk("issue_has_data", mq_data.size() != 0, 1);
                if (mq_data.size() != 0) begin
                    out_data = mq_data.pop_front();
                    out_last = mq_last.pop_front();
                    outstanding = 1;
                    issue_t = cyc;
                    n_issue++;
                    issue_cyc.push_back(cyc);
                    chk("dac_code", dac_code, expand(out_data));
                    chk("row_at_issue", row_idx, model_row);
                    out_resp = resp_en;
                    if (resp_en) dly = resp_lat - 1;
                end
            end
            prev_valid = dac_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        nclk(2);
        check_reset_outputs("reset");
        rst = 1'b0;
        nclk();

        // Single last element 255: issue 2 cycles after accept, done 4 later
        push(255, 1);
        chk("t1_c1_valid", dac_valid, 0);
        nclk();
        chk("t1_c2_valid", dac_valid, 1);
        chk("t1_c2_code", dac_code, 1023);
        chk("t1_c2_row", row_idx, 0);
        nclk();
        chk("t1_c3_valid", dac_valid, 0);
        chk("t1_c3_code_hold", dac_code, 1023);
        nclk(3);
        chk("t1_c6_busy", busy, 1);
        nclk();
        chk("t1_c7_vec_done", vec_done, 1);
        chk("t1_c7_row", row_idx, 0);
        chk("t1_c7_busy", busy, 0);
        nclk();
        chk("t1_c8_vec_done", vec_done, 0);

        // Vector 0,1,128,200 then a random vector; FIFO fills, 5-cycle cadence
        issue_cyc.delete();
        saw_full = 0;
        push(0, 0);
        push(1, 0);
        push(128, 0);
        push(200, 1);
        for (int i = 0; i < 8; i++) push($urandom_range(0, 255), i == 7);
        wait_idle();
        chk("t2_in_ready_dropped", saw_full, 1);
        chk("t2_issue_count", issue_cyc.size(), 12);
        for (int i = 1; i < issue_cyc.size(); i++)
            chk("t2_issue_spacing", issue_cyc[i] - issue_cyc[i-1], 5);
        chk("t2_row_end", row_idx, 0);

        // Push and pop in the same cycle with two entries held, then timeout
        push($urandom_range(1, 255), 0);
        push($urandom_range(1, 255), 0);
        push($urandom_range(1, 255), 0);
        resp_en = 0;
        for (int g = 0; g < 20 && !dac_done; g++) nclk();
        chk("t3_done_seen", dac_done, 1);
        push($urandom_range(1, 255), 0);
        push($urandom_range(1, 255), 0);
        push($urandom_range(1, 255), 0);
        chk("t3_full_after_pushpop", in_ready, 0);
        for (int g = 0; g < 40 && !err_timeout; g++) nclk();
        chk("t4_err_seen", err_timeout, 1);
        resp_en = 1;
        err_clr = 1'b1;
        nclk();
        err_clr = 1'b0;
        chk("t4_err_cleared", err_timeout, 0);
        wait_idle();
        chk("t4_row_end", row_idx, model_row);

        // Spurious dac_done while idle
        spur_done = 1'b1;
        nclk();
        spur_done = 1'b0;
        nclk();
        chk("t5_row_unchanged", row_idx, model_row);
        chk("t5_busy", busy, 0);
        chk("t5_valid", dac_valid, 0);
        push($urandom_range(1, 255), 0);
        wait_idle();

        // Reset while waiting with three entries buffered
        resp_en = 0;
        for (int i = 0; i < 5; i++) push($urandom_range(1, 255), 0);
        for (int g = 0; g < 40 && !err_timeout; g++) nclk();
        chk("t6_err_seen", err_timeout, 1);
        nclk(3);
        chk("t6_busy_before_reset", busy, 1);
        rst = 1'b1;
        nclk();
        check_reset_outputs("midrst");
        rst = 1'b0;
        n_push = 0;
        n_issue = 0;
        resp_en = 1;
        spur_done = 1'b1;
        nclk();
        spur_done = 1'b0;
        nclk(4);
        check_reset_outputs("late_done");
        chk("model_queue_empty", mq_data.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
